multi_dataflow_job_sequencer: RTL and testbench

//  Job-level controller for the multi_dataflow engine and its streamers.
//  - Accepts a job trigger from the register-file control slave.
//  - Clears and starts the engine and streamers, and counts outStream0 beats against the job length.
//  - Waits for the sink streamer to flush, guards every wait with a no-progress watchdog,
//    and raises done/error events to the event unit.

---
 rtl/multi_dataflow_job_sequencer_pkg.sv | 18 +
 rtl/multi_dataflow_job_sequencer_if.sv | 40 ++++
 rtl/multi_dataflow_watchdog.sv | 21 ++
 rtl/multi_dataflow_job_sequencer.sv | 98 +++++++++
 tb/tb_multi_dataflow_job_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/multi_dataflow_job_sequencer_pkg.sv
// multi_dataflow_package: shared types and widths for the job sequencer
package multi_dataflow_package;

    localparam int SEQ_LEN_W = 32;
    localparam int SEQ_TO_W  = 16;

    typedef enum logic [2:0] {
        IDLE, CLEAR, WAIT_RDY, START, RUN, FLUSH, DONE, ERR
    } seq_state_e;

    typedef struct packed {
        logic       busy;
        logic       err_to;
        logic       err_ovr;
        logic [2:0] state;
    } seq_status_t;

endpackage

// File: rtl/multi_dataflow_job_sequencer_if.sv
// multi_dataflow_job_sequencer_if: control, engine and stream-observe signals of the job sequencer
interface multi_dataflow_job_sequencer_if
    import multi_dataflow_package::*;
#(
    parameter int LEN_W = SEQ_LEN_W,
    parameter int TO_W  = SEQ_TO_W
);
    logic             clear_i;
    logic             job_start_i;
    logic [LEN_W-1:0] job_len_i;
    logic [TO_W-1:0]  timeout_i;
    logic             eng_ready_i;
    logic             out_valid_i;
    logic             out_ready_i;
    logic             sink_done_i;
    logic             eng_clear_o;
    logic             eng_start_o;
    logic             strm_start_o;
    logic             busy_o;
    logic             evt_done_o;
    logic             evt_err_o;
    logic             err_to_o;
    logic             err_ovr_o;
    logic [LEN_W-1:0] beat_cnt_o;
    logic [2:0]       state_o;

    modport slave (
        input  clear_i, job_start_i, job_len_i, timeout_i, eng_ready_i,
               out_valid_i, out_ready_i, sink_done_i,
        output eng_clear_o, eng_start_o, strm_start_o, busy_o, evt_done_o,
               evt_err_o, err_to_o, err_ovr_o, beat_cnt_o, state_o
    );

    modport master (
        output clear_i, job_start_i, job_len_i, timeout_i, eng_ready_i,
               out_valid_i, out_ready_i, sink_done_i,
        input  eng_clear_o, eng_start_o, strm_start_o, busy_o, evt_done_o,
               evt_err_o, err_to_o, err_ovr_o, beat_cnt_o, state_o
    );
endinterface

// File: rtl/multi_dataflow_watchdog.sv
// multi_dataflow_watchdog: saturating no-progress counter; expired flags the cycle that reaches limit
module multi_dataflow_watchdog #(
    parameter int TO_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expired
);
    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt <= '0;
        else if (clr || !en) cnt <= '0;
        else if (cnt != '1) cnt <= cnt + TO_W'(1);
    end

    assign expired = en && !clr && (limit != '0) && (cnt == limit - TO_W'(1));
endmodule

// File: rtl/multi_dataflow_job_sequencer.sv
// multi_dataflow_job_sequencer: job FSM that clears/starts the engine, counts output beats and reports done/error
module multi_dataflow_job_sequencer
    import multi_dataflow_package::*;
#(
    parameter int LEN_W = SEQ_LEN_W,
    parameter int TO_W  = SEQ_TO_W
) (
    input logic                           clk_i,
    input logic                           rst_i,
    multi_dataflow_job_sequencer_if.slave bus
);
    localparam logic [2:0] ST_IDLE     = IDLE;
    localparam logic [2:0] ST_CLEAR    = CLEAR;
    localparam logic [2:0] ST_WAIT_RDY = WAIT_RDY;
    localparam logic [2:0] ST_START    = START;
    localparam logic [2:0] ST_RUN      = RUN;
    localparam logic [2:0] ST_FLUSH    = FLUSH;
    localparam logic [2:0] ST_DONE     = DONE;
    localparam logic [2:0] ST_ERR      = ERR;

    logic [2:0]       state, state_nxt;
    logic [LEN_W-1:0] len_q, cnt_q;
    logic [TO_W-1:0]  to_q;
    logic             err_to_q, err_ovr_q;
    logic             beat, last, accept, busy, wd_en, wd_exp;
    seq_status_t      status;

    assign beat   = bus.out_valid_i & bus.out_ready_i;
    assign last   = beat && (cnt_q + LEN_W'(1) == len_q);
    assign busy   = state != ST_IDLE;
    assign accept = !busy && bus.job_start_i;
    assign wd_en  = state == ST_WAIT_RDY || state == ST_RUN || state == ST_FLUSH;

    multi_dataflow_watchdog #(.TO_W(TO_W)) u_wd (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (beat | bus.clear_i),
        .en      (wd_en),
        .limit   (to_q),
        .expired (wd_exp)
    );

    // progress conditions take priority over a watchdog expiry in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (bus.job_start_i) state_nxt = (bus.job_len_i != '0) ? ST_CLEAR : ST_DONE;
            ST_CLEAR:    state_nxt = ST_WAIT_RDY;
            ST_WAIT_RDY: state_nxt = bus.eng_ready_i ? ST_START : wd_exp ? ST_ERR : state;
            ST_START:    state_nxt = ST_RUN;
            ST_RUN:      state_nxt = last ? ST_FLUSH : wd_exp ? ST_ERR : state;
            ST_FLUSH:    state_nxt = bus.sink_done_i ? ST_DONE : wd_exp ? ST_ERR : state;
            default:     state_nxt = ST_IDLE;
        endcase
        if (bus.clear_i) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            to_q      <= '0;
            cnt_q     <= '0;
            err_to_q  <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (bus.clear_i) begin
                cnt_q     <= '0;
                err_to_q  <= 1'b0;
                err_ovr_q <= 1'b0;
            end else if (accept) begin
                len_q     <= bus.job_len_i;
                to_q      <= bus.timeout_i;
                cnt_q     <= '0;
                err_to_q  <= 1'b0;
                err_ovr_q <= 1'b0;
            end else begin
                if (state == ST_RUN && beat) cnt_q <= cnt_q + LEN_W'(1);
                if (busy && state != ST_RUN && beat) err_ovr_q <= 1'b1;
                if (state_nxt == ST_ERR) err_to_q <= 1'b1;
            end
        end
    end

    assign status = '{busy: busy, err_to: err_to_q, err_ovr: err_ovr_q, state: state};

    assign bus.eng_clear_o  = state == ST_CLEAR || state == ST_ERR || bus.clear_i;
    assign bus.eng_start_o  = state == ST_START;
    assign bus.strm_start_o = state == ST_START;
    assign bus.evt_done_o   = state == ST_DONE;
    assign bus.evt_err_o    = state == ST_ERR;
    assign bus.busy_o       = status.busy;
    assign bus.err_to_o     = status.err_to;
    assign bus.err_ovr_o    = status.err_ovr;
    assign bus.state_o      = status.state;
    assign bus.beat_cnt_o   = cnt_q;
endmodule

// File: tb/tb_multi_dataflow_job_sequencer.sv
// tb_multi_dataflow_job_sequencer: vector table for the nominal/zero-length jobs plus directed corner sequences
module tb_multi_dataflow_job_sequencer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;

    multi_dataflow_job_sequencer_if bus();

    multi_dataflow_job_sequencer dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st;
        logic [31:0] len;
        logic [15:0] to;
        logic        rdy, v, r, sd, clr;
        logic        e_clr, e_start, e_busy, e_done, e_err;
        logic [2:0]  e_state;
        logic        ck;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic idle_in();
        bus.clear_i = 0; bus.job_start_i = 0; bus.job_len_i = 0; bus.timeout_i = 0;
        bus.out_valid_i = 0; bus.out_ready_i = 0; bus.sink_done_i = 0; bus.eng_ready_i = 1;
    endtask

    task automatic to_run(input logic [31:0] len, input logic [15:0] to);
        bus.job_start_i = 1; bus.job_len_i = len; bus.timeout_i = to; bus.eng_ready_i = 1;
        step();
        bus.job_start_i = 0;
        for (int n = 0; n < 10 && bus.state_o != 3'd4; n++) step();
        chk("reach_run", 32'(bus.state_o), 32'd4);
    endtask

    initial begin
        int   n;
        logic seen;
        idle_in();
        #12;
        chk("rst_state", 32'(bus.state_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_cnt", bus.beat_cnt_o, 0);
        chk("rst_errs", 32'({bus.err_to_o, bus.err_ovr_o, bus.evt_done_o, bus.evt_err_o, bus.eng_start_o}), 0);
        @(negedge clk_i) rst_i = 0;
        step();

        // st len to rdy v r sd clr | clr start busy done err state ck cnt
        vq.push_back('{1, 4, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 0});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 1, 1, 0});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 2, 1, 0});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 1, 0, 0, 3, 1, 0});
        vq.push_back('{0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0, 4, 1, 0});
        vq.push_back('{1, 9, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0, 4, 1, 1});
        vq.push_back('{0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0, 4, 1, 2});
        vq.push_back('{0, 0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 0, 4, 1, 3});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 5, 1, 4});
        vq.push_back('{0, 0, 0, 1, 0, 0, 1, 0,  0, 0, 1, 0, 0, 5, 1, 4});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 6, 1, 4});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 4});
        vq.push_back('{1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 4});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 1, 0, 6, 0, 0});
        vq.push_back('{0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0});

        foreach (vq[i]) begin
            bus.job_start_i = vq[i].st; bus.job_len_i = vq[i].len; bus.timeout_i = vq[i].to;
            bus.eng_ready_i = vq[i].rdy; bus.out_valid_i = vq[i].v; bus.out_ready_i = vq[i].r;
            bus.sink_done_i = vq[i].sd; bus.clear_i = vq[i].clr;
            #1;
            chk($sformatf("row%0d eng_clear", i), 32'(bus.eng_clear_o), 32'(vq[i].e_clr));
            chk($sformatf("row%0d eng_start", i), 32'(bus.eng_start_o), 32'(vq[i].e_start));
            chk($sformatf("row%0d strm_start", i), 32'(bus.strm_start_o), 32'(vq[i].e_start));
            chk($sformatf("row%0d busy", i), 32'(bus.busy_o), 32'(vq[i].e_busy));
            chk($sformatf("row%0d evt_done", i), 32'(bus.evt_done_o), 32'(vq[i].e_done));
            chk($sformatf("row%0d evt_err", i), 32'(bus.evt_err_o), 32'(vq[i].e_err));
            chk($sformatf("row%0d state", i), 32'(bus.state_o), 32'(vq[i].e_state));
            if (vq[i].ck) chk($sformatf("row%0d beat_cnt", i), bus.beat_cnt_o, vq[i].e_cnt);
            step();
        end
        idle_in();
        step();

        // watchdog: 3 beats then stall
        to_run(8, 10);
        bus.out_valid_i = 1; bus.out_ready_i = 1;
        step(); step(); step();
        bus.out_valid_i = 0;
        n = 0;
        while (!bus.evt_err_o && n < 30) begin step(); n++; end
        chk("to_stall_cycles", n, 10);
        chk("to_eng_clear", 32'(bus.eng_clear_o), 1);
        chk("to_err_to", 32'(bus.err_to_o), 1);
        chk("to_beat_cnt", bus.beat_cnt_o, 3);
        chk("to_state", 32'(bus.state_o), 7);
        step();
        chk("to_idle", 32'(bus.state_o), 0);
        chk("to_sticky", 32'(bus.err_to_o), 1);
        chk("to_err_pulse", 32'(bus.evt_err_o), 0);

        // overrun: third beat arrives in FLUSH
        to_run(2, 0);
        bus.out_valid_i = 1; bus.out_ready_i = 1;
        step(); step();
        chk("ovr_flush", 32'(bus.state_o), 5);
        chk("ovr_clr_to", 32'(bus.err_to_o), 0);
        step();
        bus.out_valid_i = 0; bus.sink_done_i = 1;
        #1;
        chk("ovr_flag", 32'(bus.err_ovr_o), 1);
        step();
        bus.sink_done_i = 0;
        chk("ovr_done", 32'(bus.evt_done_o), 1);
        chk("ovr_cnt", bus.beat_cnt_o, 2);
        step();
        chk("ovr_sticky", 32'(bus.err_ovr_o), 1);

        // back-pressure: late engine ready, toggling out_ready
        bus.eng_ready_i = 0; bus.job_start_i = 1; bus.job_len_i = 6;
        step();
        bus.job_start_i = 0;
        step();
        seen = 0;
        for (int k = 0; k < 5; k++) begin seen |= bus.eng_start_o; step(); end
        chk("bp_no_early_start", 32'(seen), 0);
        chk("bp_wait", 32'(bus.state_o), 2);
        bus.eng_ready_i = 1;
        step();
        chk("bp_start", 32'(bus.eng_start_o), 1);
        step();
        bus.out_valid_i = 1;
        n = 0;
        while (bus.state_o != 3'd5 && n < 40) begin bus.out_ready_i = (n % 2 == 0); step(); n++; end
        bus.out_valid_i = 0; bus.out_ready_i = 0;
        chk("bp_cycles", n, 11);
        chk("bp_cnt", bus.beat_cnt_o, 6);
        chk("bp_no_ovr", 32'(bus.err_ovr_o), 0);
        bus.sink_done_i = 1;
        step();
        bus.sink_done_i = 0;
        chk("bp_done", 32'(bus.evt_done_o), 1);
        step();

        // clear_i together with job_start_i
        bus.clear_i = 1; bus.job_start_i = 1; bus.job_len_i = 4;
        #1;
        chk("clr_comb", 32'(bus.eng_clear_o), 1);
        step();
        bus.clear_i = 0; bus.job_start_i = 0;
        chk("clr_start_idle", 32'(bus.state_o), 0);
        chk("clr_start_busy", 32'(bus.busy_o), 0);
        step();
        chk("clr_start_stay", 32'(bus.state_o), 0);

        // clear_i mid-RUN
        to_run(5, 0);
        bus.out_valid_i = 1; bus.out_ready_i = 1;
        step(); step();
        bus.out_valid_i = 0;
        chk("clr_run_cnt", bus.beat_cnt_o, 2);
        bus.clear_i = 1;
        #1;
        chk("clr_run_comb", 32'(bus.eng_clear_o), 1);
        step();
        bus.clear_i = 0;
        chk("clr_run_idle", 32'(bus.state_o), 0);
        chk("clr_run_cnt0", bus.beat_cnt_o, 0);
        seen = 0;
        for (int k = 0; k < 3; k++) begin seen |= bus.evt_done_o | bus.evt_err_o | bus.err_ovr_o | bus.err_to_o; step(); end
        chk("clr_run_no_evt", 32'(seen), 0);

        // asynchronous reset mid-RUN
        to_run(5, 0);
        bus.out_valid_i = 1; bus.out_ready_i = 1;
        step(); step();
        bus.out_valid_i = 0;
        rst_i = 1;
        #1;
        chk("arst_state", 32'(bus.state_o), 0);
        chk("arst_busy", 32'(bus.busy_o), 0);
        chk("arst_cnt", bus.beat_cnt_o, 0);
        chk("arst_outs", 32'({bus.eng_clear_o, bus.eng_start_o, bus.strm_start_o, bus.evt_done_o, bus.evt_err_o}), 0);
        @(negedge clk_i) rst_i = 0;
        step();
        chk("arst_after", 32'(bus.state_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
